// File: rtl/dmem_responder.sv
// Word-organised single-port data RAM answering each dmem request with one resp pulse.
// Optional build macro DMEM_RANDOM_WAIT_EN adds 0..3 LFSR-driven extra wait cycles per request.
`ifndef XLEN
`define XLEN 32
`endif

module dmem_responder #(
    parameter int unsigned DEPTH     = 4096,
    parameter int unsigned LATENCY   = 1,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dmem_req,
    input  logic              dmem_cmd,
    input  logic [1:0]        dmem_width,
    input  logic [`XLEN-1:0]  dmem_addr,
    input  logic [`XLEN-1:0]  dmem_wdata,
    output logic [`XLEN-1:0]  dmem_rdata,
    output logic              dmem_resp,
    output logic              err_misalign,
    output logic              err_overrun
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t         state;
    logic [4:0]     cnt;
    logic           pend_read;
    logic [31:0]    rd_buf;
    logic [31:0]    mem [DEPTH];

    logic           accept;
    logic           overrun;
    logic           misalign;
    logic [AW-1:0]  idx;
    logic [3:0]     be;
    logic [31:0]    wword;
    logic [31:0]    rd_val;
    logic [4:0]     wait_total;
    logic           unused_addr;

    assign accept      = rst && dmem_req && (state == IDLE || state == RESP);
    assign overrun     = dmem_req && (state == WAIT);
    assign idx         = dmem_addr[AW+1:2];
    assign unused_addr = ^dmem_addr[`XLEN-1:AW+2];

    // Write data is replicated across lanes so the byte enables alone pick the target lane.
    always_comb begin
        misalign = 1'b0;
        be       = '1;
        wword    = dmem_wdata[31:0];
        case (dmem_width)
            2'd0: begin
                be    = 4'b0001 << dmem_addr[1:0];
                wword = {4{dmem_wdata[7:0]}};
            end
            2'd1: begin
                misalign = dmem_addr[0];
                be       = dmem_addr[1] ? 4'b1100 : 4'b0011;
                wword    = {2{dmem_wdata[15:0]}};
            end
            default: misalign = |dmem_addr[1:0];
        endcase
        rd_val = misalign ? '0 : mem[idx];
    end

`ifdef DMEM_RANDOM_WAIT_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr <= LFSR_SEED;
        else      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign wait_total = 5'(LATENCY) + {3'b000, lfsr[1:0]};
`else
    assign wait_total = 5'(LATENCY);
`endif

    always_ff @(posedge clk) begin
        if (accept && dmem_cmd && !misalign) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            pend_read    <= 1'b0;
            rd_buf       <= '0;
            dmem_resp    <= 1'b0;
            dmem_rdata   <= '0;
            err_misalign <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            dmem_resp <= 1'b0;
            if (overrun)             err_overrun  <= 1'b1;
            if (accept && misalign)  err_misalign <= 1'b1;
            case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        pend_read <= !dmem_cmd;
                        rd_buf    <= rd_val;
                        if (wait_total == 5'd0) begin
                            state     <= RESP;
                            dmem_resp <= 1'b1;
                            if (!dmem_cmd) dmem_rdata <= rd_val;
                        end else begin
                            state <= WAIT;
                            cnt   <= wait_total - 5'd1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt == 5'd0) begin
                        state     <= RESP;
                        dmem_resp <= 1'b1;
                        if (pend_read) dmem_rdata <= rd_buf;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances at LATENCY 0, 1 and 3 share clock and reset.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req   [3];
    logic        cmd   [3];
    logic [1:0]  width [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic        resp  [3];
    logic        emis  [3];
    logic        eovr  [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.LATENCY(0)) u_lat0 (
        .clk(clk), .rst(rst), .dmem_req(req[0]), .dmem_cmd(cmd[0]), .dmem_width(width[0]),
        .dmem_addr(addr[0]), .dmem_wdata(wdata[0]), .dmem_rdata(rdata[0]), .dmem_resp(resp[0]),
        .err_misalign(emis[0]), .err_overrun(eovr[0]));

    dmem_responder #(.LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst), .dmem_req(req[1]), .dmem_cmd(cmd[1]), .dmem_width(width[1]),
        .dmem_addr(addr[1]), .dmem_wdata(wdata[1]), .dmem_rdata(rdata[1]), .dmem_resp(resp[1]),
        .err_misalign(emis[1]), .err_overrun(eovr[1]));

    dmem_responder #(.LATENCY(3)) u_lat3 (
        .clk(clk), .rst(rst), .dmem_req(req[2]), .dmem_cmd(cmd[2]), .dmem_width(width[2]),
        .dmem_addr(addr[2]), .dmem_wdata(wdata[2]), .dmem_rdata(rdata[2]), .dmem_resp(resp[2]),
        .err_misalign(emis[2]), .err_overrun(eovr[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One request, then count negedges until resp; the count must equal LATENCY+1.
    task automatic txn(input int k, input logic c, input logic [1:0] w, input logic [31:0] a,
                       input logic [31:0] d, input int lat, input string tag);
        int n;
        @(negedge clk);
        req[k] = 1'b1; cmd[k] = c; width[k] = w; addr[k] = a; wdata[k] = d;
        @(negedge clk);
        req[k] = 1'b0;
        n = 1;
        while (!resp[k] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(lat + 1));
    endtask

    initial begin
        int nresp;
        int first;
        for (int k = 0; k < 3; k++) begin
            req[k] = 1'b0; cmd[k] = 1'b0; width[k] = 2'd2; addr[k] = '0; wdata[k] = '0;
        end
        repeat (2) @(negedge clk);
        check("reset rdata", rdata[1], 32'h0);
        check("reset resp", 32'(resp[1]), 32'h0);
        check("reset err_misalign", 32'(emis[1]), 32'h0);
        check("reset err_overrun", 32'(eovr[1]), 32'h0);
        rst = 1'b1;

        // LATENCY=1: word write and readback
        txn(1, 1'b1, 2'd2, 32'h100, 32'hDEADBEEF, 1, "wr word");
        txn(1, 1'b0, 2'd2, 32'h100, 32'h0, 1, "rd word");
        check("rd word data", rdata[1], 32'hDEADBEEF);

        // Byte and half lanes over a zeroed word
        txn(1, 1'b1, 2'd2, 32'h100, 32'h0, 1, "wr zero");
        txn(1, 1'b1, 2'd0, 32'h101, 32'hFFFFFF5A, 1, "wr byte");
        txn(1, 1'b1, 2'd1, 32'h102, 32'hFFFF1234, 1, "wr half");
        txn(1, 1'b0, 2'd0, 32'h100, 32'h0, 1, "rd lanes");
        check("rd lanes data", rdata[1], 32'h12345A00);
        check("no misalign yet", 32'(emis[1]), 32'h0);

        // Misaligned write suppressed, misaligned read returns zero
        txn(1, 1'b1, 2'd2, 32'h102, 32'hFFFFFFFF, 1, "mis wr");
        check("err_misalign set", 32'(emis[1]), 32'h1);
        txn(1, 1'b0, 2'd2, 32'h100, 32'h0, 1, "rd after mis wr");
        check("mis wr suppressed", rdata[1], 32'h12345A00);
        txn(1, 1'b0, 2'd1, 32'h101, 32'h0, 1, "mis rd");
        check("mis rd zero", rdata[1], 32'h0);
        txn(1, 1'b0, 2'd2, 32'h4100, 32'h0, 1, "alias rd");
        check("alias rd data", rdata[1], 32'h12345A00);
        txn(1, 1'b1, 2'd2, 32'h200, 32'h87654321, 1, "wr keeps rdata");
        check("wr keeps rdata data", rdata[1], 32'h12345A00);
        check("err_misalign sticky", 32'(emis[1]), 32'h1);
        check("lat1 no overrun", 32'(eovr[1]), 32'h0);

        // LATENCY=0: preload, then three back-to-back reads
        txn(0, 1'b1, 2'd2, 32'h0, 32'h11111111, 0, "l0 wr0");
        txn(0, 1'b1, 2'd2, 32'h4, 32'h22222222, 0, "l0 wr1");
        txn(0, 1'b1, 2'd2, 32'h8, 32'h33333333, 0, "l0 wr2");
        @(negedge clk);
        req[0] = 1'b1; cmd[0] = 1'b0; width[0] = 2'd2; addr[0] = 32'h0;
        @(negedge clk);
        check("b2b resp0", 32'(resp[0]), 32'h1);
        check("b2b data0", rdata[0], 32'h11111111);
        addr[0] = 32'h4;
        @(negedge clk);
        check("b2b resp1", 32'(resp[0]), 32'h1);
        check("b2b data1", rdata[0], 32'h22222222);
        addr[0] = 32'h8;
        @(negedge clk);
        check("b2b resp2", 32'(resp[0]), 32'h1);
        check("b2b data2", rdata[0], 32'h33333333);
        req[0] = 1'b0;
        @(negedge clk);
        check("b2b idle", 32'(resp[0]), 32'h0);
        check("b2b no overrun", 32'(eovr[0]), 32'h0);

        // LATENCY=3: a write arriving during WAIT is dropped
        txn(2, 1'b1, 2'd2, 32'h20, 32'hCAFEF00D, 3, "l3 wr");
        @(negedge clk);
        req[2] = 1'b1; cmd[2] = 1'b0; width[2] = 2'd2; addr[2] = 32'h20;
        nresp = 0;
        first = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (resp[2]) begin
                nresp++;
                if (first == 0) first = n;
            end
            if (n == 1) begin
                cmd[2] = 1'b1; wdata[2] = 32'h0BADBAD0;
            end else begin
                req[2] = 1'b0;
            end
        end
        check("ovr resp count", 32'(nresp), 32'd1);
        check("ovr resp time", 32'(first), 32'd4);
        check("ovr rd data", rdata[2], 32'hCAFEF00D);
        check("err_overrun set", 32'(eovr[2]), 32'h1);
        txn(2, 1'b0, 2'd2, 32'h20, 32'h0, 3, "ovr reread");
        check("dropped wr no effect", rdata[2], 32'hCAFEF00D);
        check("err_overrun sticky", 32'(eovr[2]), 32'h1);

        // Reset during WAIT abandons the read
        @(negedge clk);
        req[1] = 1'b1; cmd[1] = 1'b0; width[1] = 2'd2; addr[1] = 32'h100;
        @(negedge clk);
        req[1] = 1'b0;
        rst = 1'b0;
        #1;
        check("mid rst resp", 32'(resp[1]), 32'h0);
        check("mid rst rdata", rdata[1], 32'h0);
        check("mid rst misalign", 32'(emis[1]), 32'h0);
        check("mid rst overrun", 32'(eovr[2]), 32'h0);
        nresp = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (resp[1]) nresp++;
            if (n == 1) rst = 1'b1;
        end
        check("mid rst no resp", 32'(nresp), 32'd0);
        txn(1, 1'b0, 2'd2, 32'h100, 32'h0, 1, "post rst rd");
        check("post rst data", rdata[1], 32'h12345A00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory slave at the far end of the core's dmem request/response interface: a single-ported, word-organised, on-chip RAM.
- Answers each dmem_req with exactly one dmem_resp after a programmable wait.
- Performs byte-lane writes and detects misaligned and overrun requests.
- Instantiated beside the CPU top in the SoC/testbench; also serves as the reference memory model for core regression.

Parameters:
- DEPTH, 4096: number of 32-bit words; power of two; index bits AW = log2(DEPTH).
- LATENCY, 1: wait cycles between accept and resp; range 0..15.
- LFSR_SEED, 8'hA5: nonzero seed for the optional random-wait LFSR.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low (rst==0 resets).
- dmem_req  input  1  single-cycle request strobe, one per transaction.
- dmem_cmd  input  1  1=write, 0=read.
- dmem_width  input  2  0=byte, 1=half, 2=word, 3=treated as word.
- dmem_addr  input  `XLEN  byte address.
- dmem_wdata  input  `XLEN  write data, right-aligned.
- dmem_rdata  output  `XLEN  read data: full aligned word.
- dmem_resp  output  1  one-cycle completion pulse.
- err_misalign  output  1  sticky; misaligned request seen.
- err_overrun  output  1  sticky; req arrived while busy.

Behaviour:
- Reset state: IDLE; dmem_resp=0, dmem_rdata=0, err_misalign=0, err_overrun=0, wait counter=0, LFSR=LFSR_SEED. RAM contents are not reset.
- Reset asserted mid-transaction: the transaction is abandoned and no resp is issued. A write already committed at its accept edge remains in RAM.
- FSM states: IDLE, WAIT, RESP.
- Accept: dmem_req=1 while in IDLE or RESP. All request fields are sampled at that edge.
  - Next state is WAIT with counter=LATENCY-1 if LATENCY>0.
  - Next state is RESP if LATENCY=0.
- WAIT: counter decrements each cycle; moves to RESP when counter==0.
- RESP: dmem_resp=1 for exactly this cycle. Next state is IDLE unless a new req is accepted in the same cycle (back-to-back).
- Latency: accept at edge T gives dmem_resp high in cycle T+1+LATENCY. Maximum throughput is one transaction per LATENCY+1 cycles.
- Overrun: dmem_req=1 while in WAIT.
  - The request is dropped: no RAM access, no resp.
  - err_overrun sets and stays set until reset.
  - The in-flight transaction completes unaffected.
- Word index: dmem_addr[AW+1:2]. Upper address bits are ignored, so addresses alias/wrap modulo DEPTH*4.
- Alignment rules:
  - Half: addr[0] must be 0.
  - Word: addr[1:0] must be 0.
  - Byte: always aligned.
- Write (cmd=1, aligned), committed to RAM at the accept edge:
  - Byte: wdata[7:0] goes to lane addr[1:0].
  - Half: wdata[15:0] goes to lanes {addr[1],0}+1 : {addr[1],0}.
  - Word: all lanes written.
  - Other lanes are preserved.
- Read (cmd=0, aligned):
  - The word at the index is captured at the accept edge and driven on dmem_rdata from the RESP cycle onward.
  - dmem_rdata holds that value until the next read's RESP.
  - Width has no effect on reads; the initiator extracts lanes and extends.
- Misaligned request: still accepted and still responded with normal timing.
  - Write is suppressed.
  - Read returns dmem_rdata=0.
  - err_misalign sets (sticky).
- Read-after-write: a read accepted after a write's RESP returns the new data. An accept in the RESP cycle counts as after.
- A write gives a resp pulse; dmem_rdata is unchanged.

Optional Feature:
- Macro: DMEM_RANDOM_WAIT_EN.
- When defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) advances every cycle outside reset.
  - On each accept, extra = LFSR[1:0] (0..3) wait cycles are added.
  - Latency becomes 1+LATENCY+extra. WAIT is entered even when LATENCY=0 and extra>0.
- When undefined: no LFSR is present and latency is fixed at 1+LATENCY.

Test Plan:
- Reset, LATENCY=1: word write 0xDEADBEEF to 0x100, then read 0x100 → resp exactly 2 cycles after each accept; rdata=0xDEADBEEF.
- Byte write 0x5A to 0x101, half write 0x1234 to 0x102 over word 0x00000000 → read 0x100 returns 0x12345A00.
- LATENCY=0, back-to-back: read reqs to 0x0, 0x4, 0x8 on consecutive resp cycles → three resps in consecutive cycles, each carrying the correct word; err_overrun=0.
- LATENCY=3: second req 1 cycle after the first accept → second req dropped; exactly one resp; err_overrun=1 and stays set.
- Misaligned word write to 0x102 with 0xFFFFFFFF, then read 0x100 → write suppressed; misaligned read returns 0; err_misalign=1; both requests receive a resp.
- Assert rst=0 during WAIT after a read accept → no resp; all outputs zero; after release, a new read completes normally.
